// File: rtl/uart_tx_arb.sv
// ---------------------------------------------------------------------------
// uart_tx_arb
//
// Shares one uart_tx byte interface between NREQ byte requesters. Unlocked
// selection is round-robin starting at rr_ptr. Once a requester wins, it
// keeps ownership (lock) until it sends a byte flagged last. The lock is
// also dropped if the owner stays idle for LOCK_TIMEOUT cycles.
//
// Each byte goes through IDLE -> SEND -> DRAIN. DRAIN waits for utx_ack to
// fall, so uart_tx always sees a fresh rising edge of utx_valid.
//
// Handshakes:
//   requester side: req_valid[i] is a level. req_ready[i] is a one-cycle
//     pulse that appears the cycle after the byte was captured. The
//     requester may change req_data/req_last or drop req_valid from then on.
//   uart_tx side: utx_valid rises with utx_data stable and stays high until
//     utx_ack is seen high. utx_valid then stays low until utx_ack has been
//     seen low. utx_ack outside SEND/DRAIN is ignored.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_valid[i]   requester i has a byte pending
//   req_data       byte of requester i on bits [8i+7:8i]
//   req_last[i]    pending byte of requester i ends its packet
//   req_ready[i]   one-cycle capture pulse to requester i
//   grant          one-hot current owner, zero when none
//   utx_data       byte to uart_tx
//   utx_valid      data_valid to uart_tx
//   utx_ack        tx_ack from uart_tx
//   busy           not IDLE, or holding a packet lock
// ---------------------------------------------------------------------------
module uart_tx_arb #(
  parameter int NREQ         = 3,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        utx_data,
  output logic              utx_valid,
  input  logic              utx_ack,
  output logic              busy
);

  localparam int IW       = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam int TW       = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int TMO_LAST = (LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              lock_q, lock_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [7:0]        hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [NREQ-1:0]   req_ready_q, req_ready_d;
  logic              utx_valid_q, utx_valid_d;
  logic              busy_q, busy_d;

  // candidate selection
  logic              sel_found;
  logic [IW-1:0]     sel_idx;
  logic [IW-1:0]     cand;
  logic [7:0]        sel_data;
  logic [NREQ-1:0]   sel_onehot;
  logic [IW-1:0]     owner_next;

  // Owner index plus one, wrapping at NREQ. Used whenever a lock is released.
  always_comb begin
    owner_next = owner_q + IW'(1);
    if (owner_q == IW'(NREQ - 1)) begin
      owner_next = '0;
    end
  end

  // While locked, only the owner is eligible. Otherwise take the first
  // valid requester at or after rr_ptr.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    if (lock_q) begin
      sel_found = req_valid[owner_q];
      sel_idx   = owner_q;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = IW'((int'(rr_ptr_q) + k) % NREQ);
        if (!sel_found && req_valid[cand]) begin
          sel_found = 1'b1;
          sel_idx   = cand;
        end
      end
    end
    sel_data   = req_data[{sel_idx, 3'b000} +: 8];
    sel_onehot = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = lock_q;
    tmo_cnt_d   = tmo_cnt_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    grant_d     = grant_q;
    req_ready_d = '0;
    utx_valid_d = utx_valid_q;

    case (state_q)
      ST_IDLE: begin
        utx_valid_d = 1'b0;
        if (sel_found) begin
          hold_data_d = sel_data;
          hold_last_d = req_last[sel_idx];
          req_ready_d = sel_onehot;
          grant_d     = sel_onehot;
          owner_d     = sel_idx;
          lock_d      = 1'b1;
          tmo_cnt_d   = '0;
          utx_valid_d = 1'b1;
          state_d     = ST_SEND;
        end else if (lock_q && (LOCK_TIMEOUT != 0)) begin
          // Owner idle while holding the lock: give it up after
          // LOCK_TIMEOUT consecutive cycles.
          if (tmo_cnt_q == TW'(TMO_LAST)) begin
            lock_d    = 1'b0;
            grant_d   = '0;
            rr_ptr_d  = owner_next;
            tmo_cnt_d = '0;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
          end
        end
      end

      ST_SEND: begin
        utx_valid_d = 1'b1;
        if (utx_ack) begin
          utx_valid_d = 1'b0;
          state_d     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        utx_valid_d = 1'b0;
        if (!utx_ack) begin
          state_d = ST_IDLE;
          if (hold_last_q) begin
            lock_d   = 1'b0;
            grant_d  = '0;
            rr_ptr_d = owner_next;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        utx_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || lock_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      lock_q      <= 1'b0;
      tmo_cnt_q   <= '0;
      hold_data_q <= 8'h00;
      hold_last_q <= 1'b0;
      grant_q     <= '0;
      req_ready_q <= '0;
      utx_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_q      <= lock_d;
      tmo_cnt_q   <= tmo_cnt_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      utx_valid_q <= utx_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign grant     = grant_q;
  assign utx_data  = hold_data_q;
  assign utx_valid = utx_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arb
//
// Bench for uart_tx_arb with NREQ=3 and LOCK_TIMEOUT=4. Expected bytes are
// {grant, data} records pushed to exp_q before each transfer is started.
// A monitor pops one record at every rising edge of utx_valid. An automatic
// uart_tx model acks each byte after ack_delay cycles and holds ack for
// ack_hold cycles after utx_valid falls.
// ---------------------------------------------------------------------------
module tb_uart_tx_arb;

  localparam int NREQ = 3;
  localparam int W    = NREQ + 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        utx_data;
  logic              utx_valid;
  logic              utx_ack;
  logic              busy;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int ack_delay = 1;
  int ack_hold  = 0;

  uart_tx_arb #(.NREQ(NREQ), .LOCK_TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .utx_data  (utx_data),
    .utx_valid (utx_valid),
    .utx_ack   (utx_ack),
    .busy      (busy)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // driver tasks
  task automatic wait_ready(input string name, output logic [NREQ-1:0] got);
    got = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        got = req_ready;
        break;
      end
    end
    if (got == '0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no req_ready expected a pulse", name);
    end
  endtask

  task automatic wait_idle(input string name);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout: got busy=1 expected busy=0", name);
    end
  endtask

  // Counts negedges with utx_valid low between a fall and the next rise.
  // Also records grant at the 5th and 6th low negedges.
  task automatic measure_gap(input string name, output int low,
                             output logic [NREQ-1:0] g5, output logic [NREQ-1:0] g6);
    low = 0;
    g5  = '0;
    g6  = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!utx_valid) break;
    end
    low = 1;
    while (low < 40) begin
      @(negedge clk);
      if (utx_valid) break;
      low++;
      if (low == 5) g5 = grant;
      if (low == 6) g6 = grant;
    end
    if (low >= 40) begin
      checks++;
      errors++;
      $display("FAIL %s_gap_timeout: got no second utx_valid", name);
    end
  endtask

  // uart_tx model
  initial begin
    utx_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (utx_valid && !utx_ack && !rst) begin
        repeat (ack_delay) @(negedge clk);
        utx_ack = 1'b1;
        for (int n = 0; n < 50 && utx_valid; n++) @(negedge clk);
        repeat (ack_hold) @(negedge clk);
        utx_ack = 1'b0;
      end
    end
  end

  // scoreboard monitor
  initial begin
    logic            pv;
    logic [NREQ-1:0] pr;
    logic [W-1:0]    e;
    pv = 1'b0;
    pr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0;
        pr = '0;
      end else begin
        check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
        if (pr != '0) check("ready_pulse_width", 32'(req_ready), 32'd0);
        if (utx_valid && !pv) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got grant=%0h data=%0h expected none", grant, utx_data);
          end else begin
            e = exp_q.pop_front();
            check("grant", 32'(grant), 32'(e[W-1:8]));
            check("utx_data", 32'(utx_data), 32'(e[7:0]));
            check("ready_at_select", 32'(req_ready), 32'(e[W-1:8]));
            check("ack_low_at_valid", 32'(utx_ack), 32'd0);
          end
        end
        pv = utx_valid;
        pr = req_ready;
      end
    end
  end

  typedef struct {
    logic [NREQ-1:0] mask;
    logic [7:0]      base;
    logic [NREQ-1:0] exp_grant;
    logic [7:0]      exp_data;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [NREQ-1:0] g, g5, g6;
    int low;
    logic seen;

    // Arbitration from reset (rr_ptr=0). Each vector is one byte with
    // last=1, so rr_ptr moves to winner+1 for the next vector.
    vecs[0]  = '{3'b001, 8'h41, 3'b001, 8'h41};
    vecs[1]  = '{3'b101, 8'h50, 3'b100, 8'h52};
    vecs[2]  = '{3'b110, 8'h60, 3'b010, 8'h61};
    vecs[3]  = '{3'b011, 8'h70, 3'b001, 8'h70};
    vecs[4]  = '{3'b010, 8'h80, 3'b010, 8'h81};
    vecs[5]  = '{3'b100, 8'h90, 3'b100, 8'h92};
    vecs[6]  = '{3'b111, 8'hA0, 3'b001, 8'hA0};
    vecs[7]  = '{3'b111, 8'hB0, 3'b010, 8'hB1};
    vecs[8]  = '{3'b111, 8'hC0, 3'b100, 8'hC2};
    vecs[9]  = '{3'b111, 8'hD0, 3'b001, 8'hD0};
    vecs[10] = '{3'b100, 8'hE0, 3'b100, 8'hE2};

    // reset, with requests present to show reset wins
    rst       = 1'b1;
    req_valid = '1;
    req_last  = '1;
    req_data  = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    repeat (3) @(negedge clk);
    check("rst_utx_valid", 32'(utx_valid), 32'd0);
    check("rst_utx_data", 32'(utx_data), 32'h00);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    rst       = 1'b0;
    @(negedge clk);

    // table-driven round robin, ends with rr_ptr=0
    foreach (vecs[i]) begin
      ack_delay = $urandom_range(1, 3);
      exp_q.push_back({vecs[i].exp_grant, vecs[i].exp_data});
      req_last  = '1;
      req_data  = {vecs[i].base + 8'd2, vecs[i].base + 8'd1, vecs[i].base};
      req_valid = vecs[i].mask;
      wait_ready("table", g);
      req_valid = '0;
      wait_idle("table");
      check("table_grant_cleared", 32'(grant), 32'd0);
    end
    ack_delay = 1;

    // packet lock: req0 sends 3 bytes while req1 waits
    exp_q.push_back({3'b001, 8'hA5});
    exp_q.push_back({3'b001, 8'hA6});
    exp_q.push_back({3'b001, 8'hA7});
    exp_q.push_back({3'b010, 8'hB5});
    req_last  = 3'b010;
    req_data  = {8'h00, 8'hB5, 8'hA5};
    req_valid = 3'b011;
    wait_ready("lock0", g);
    check("lock_byte0_owner", 32'(g), 32'b001);
    req_data[7:0] = 8'hA6;
    wait_ready("lock1", g);
    check("lock_byte1_owner", 32'(g), 32'b001);
    req_data[7:0] = 8'hA7;
    req_last[0]   = 1'b1;
    wait_ready("lock2", g);
    check("lock_byte2_owner", 32'(g), 32'b001);
    req_valid[0] = 1'b0;
    wait_ready("lock3", g);
    check("lock_after_last", 32'(g), 32'b010);
    req_valid = '0;
    wait_idle("lock");

    // timeout: req0 sends a non-last byte and goes quiet, req1 waits
    exp_q.push_back({3'b001, 8'hC5});
    exp_q.push_back({3'b010, 8'hD5});
    req_last  = 3'b010;
    req_data  = {8'h00, 8'hD5, 8'hC5};
    req_valid = 3'b011;
    wait_ready("tmo0", g);
    check("tmo_first_owner", 32'(g), 32'b001);
    req_valid[0] = 1'b0;
    // 1 DRAIN cycle + 4 idle locked cycles + 1 selection cycle
    measure_gap("tmo", low, g5, g6);
    check("tmo_gap_cycles", 32'(low), 32'd6);
    check("tmo_lock_held", 32'(g5), 32'b001);
    check("tmo_lock_released", 32'(g6), 32'b000);
    req_valid = '0;
    wait_idle("tmo");

    // ack held high 3 cycles after utx_valid falls
    ack_hold = 3;
    exp_q.push_back({3'b100, 8'hE5});
    exp_q.push_back({3'b100, 8'hE6});
    req_last  = 3'b000;
    req_data  = {8'hE5, 8'h00, 8'h00};
    req_valid = 3'b100;
    wait_ready("hs0", g);
    check("hs_owner", 32'(g), 32'b100);
    req_data[23:16] = 8'hE6;
    req_last[2]     = 1'b1;
    // 3 negedges of held ack + DRAIN exit + selection
    measure_gap("hs", low, g5, g6);
    check("hs_gap_cycles", 32'(low), 32'd5);
    req_valid = '0;
    wait_idle("hs");
    ack_hold = 0;

    // reset mid-SEND; the late ack lands in IDLE and is ignored
    ack_delay = 10;
    ack_hold  = 2;
    exp_q.push_back({3'b001, 8'hF5});
    req_last  = 3'b001;
    req_data  = {8'h00, 8'h00, 8'hF5};
    req_valid = 3'b001;
    wait_ready("rst0", g);
    req_valid = '0;
    check("valid_before_rst", 32'(utx_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_utx_valid", 32'(utx_valid), 32'd0);
    check("midrst_grant", 32'(grant), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | utx_valid | busy;
    end
    check("no_retry_after_rst", 32'(seen), 32'd0);
    ack_delay = 1;
    ack_hold  = 0;

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: NREQ, 3, number of byte requesters sharing one uart_tx (2..8).
REQ-002 Parameter: LOCK_TIMEOUT, 255, idle cycles after which a mid-packet lock is dropped; 0 disables the timeout.
REQ-003 Port: clk  in  1  single clock; all logic on its rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  in  NREQ  requester i has a byte pending (level).
REQ-006 Port: req_data  in  8*NREQ  byte of requester i on bits [8i+7:8i].
REQ-007 Port: req_last  in  NREQ  pending byte of requester i ends its packet.
REQ-008 Port: req_ready  out  NREQ  one-cycle pulse: byte of requester i captured.
REQ-009 Port: grant  out  NREQ  one-hot current owner; all-zero when none.
REQ-010 Port: utx_data  out  8  byte to uart_tx data.
REQ-011 Port: utx_valid  out  1  to uart_tx data_valid.
REQ-012 Port: utx_ack  in  1  from uart_tx tx_ack.
REQ-013 Port: busy  out  1  high in any state other than IDLE, or while locked.

Function
REQ-014 All outputs registered; states IDLE, SEND, DRAIN.
REQ-015 IDLE, unlocked: if any req_valid, select the first set bit at or after rr_ptr, wrapping modulo NREQ.
REQ-016 IDLE, locked: consider only req_valid[owner]; other requesters are ignored.
REQ-017 On selection at edge n: capture req_data/req_last of the winner into hold registers, pulse req_ready[winner] for exactly one cycle, set grant to the winner, set lock, assert utx_valid, enter SEND.
REQ-018 Selection to utx_valid high latency: 1 cycle (from first cycle req_valid seen in IDLE).
REQ-019 SEND: utx_valid=1, utx_data=hold byte held stable; on utx_ack=1, drive utx_valid=0 and enter DRAIN.
REQ-020 DRAIN: utx_valid=0; remain until utx_ack=0, then enter IDLE; DRAIN lasts at least 1 cycle so uart_tx sees a fresh rising edge on the next byte.
REQ-021 On DRAIN exit with hold_last=1: clear lock, clear grant, rr_ptr = (owner+1) mod NREQ.
REQ-022 On DRAIN exit with hold_last=0: keep lock and grant on the same owner.
REQ-023 Locked in IDLE with req_valid[owner]=0: count cycles; at LOCK_TIMEOUT consecutive cycles, clear lock and grant and advance rr_ptr as REQ-021; counter resets on any selection.
REQ-024 req_valid dropping while in SEND/DRAIN has no effect; the captured byte completes.
REQ-025 Simultaneous requests: exactly one winner per selection; at most one req_ready bit high in any cycle.
REQ-026 Requester may change req_data after its req_ready pulse; hold register is not affected.
REQ-027 utx_ack=1 observed in IDLE is ignored.

Reset
REQ-028 rst=1 at an edge: state=IDLE, utx_valid=0, utx_data=8'h00, req_ready=0, grant=0, busy=0, lock=0, rr_ptr=0, timeout counter=0.
REQ-029 Reset mid-SEND drops utx_valid the next edge; the in-flight byte is abandoned and not retried.
REQ-030 rst has priority over all other inputs in the same cycle.

Verification
REQ-031 Single byte: req_valid=001, data0=8'h41, last0=1 -> req_ready=001 one cycle, utx_data=8'h41 with utx_valid=1 until ack, then grant=000 and rr_ptr=1.
REQ-032 Round robin: all req_valid=111, last=111, rr_ptr=0 -> service order 0,1,2,0 with one ack each.
REQ-033 Packet lock: req0 sends 3 bytes (last on 3rd) while req1 valid throughout -> req1 granted only after req0's 3rd ack and DRAIN.
REQ-034 Timeout: LOCK_TIMEOUT=4, req0 sends last=0 byte then drops valid, req1 valid -> lock released after 4 idle cycles, req1 granted.
REQ-035 Handshake: ack held high for 3 cycles after valid drop -> remains in DRAIN, utx_valid stays 0 until ack=0, then at least 1 low cycle before next utx_valid.
REQ-036 Reset mid-SEND: rst=1 while utx_valid=1 -> next cycle utx_valid=0, grant=000, busy=0.
